cordic_packer: RTL and testbench
================================

Name: cordic_packer

Overview:
- Downstream neighbour of the unrolled CORDIC cosine datapath.
- Takes its unsigned fixed-point X result plus a sign flag and packs them into IEEE-754 single precision.
- Normalises iteratively (one bit per cycle) and rounds to nearest-even.
- Valid/ready handshake on both sides so it can sit between the CORDIC stage and the Nios custom-instruction result mux.

Parameters:
FRAC_BITS, 31, number of fractional bits in data_in; legal range 0..31. Input format is Q(32-FRAC_BITS).FRAC_BITS; default Q1.31, where 0x80000000 = 1.0.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  data_in/sign_in valid
in_ready  output  1  block can accept an input (high only in IDLE)
data_in  input  32  unsigned fixed-point magnitude
sign_in  input  1  sign to apply to the result (1 = negative)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, out_valid=0, result=0, internal mantissa/exponent/sign registers=0; in_ready=1 once reset is released. Reset mid-operation aborts the conversion; no partial result is ever presented.
- in_ready is combinational: (state==IDLE). Inputs are ignored in any other state.
- States: IDLE, NORM, ROUND, OUT.
- IDLE: on in_valid=1, latch mant=data_in, exp=127+(31-FRAC_BITS), sgn=sign_in.
  - data_in==0: load result=0x00000000 (always +0; sign ignored) and go to OUT.
  - Otherwise go to NORM.
- NORM: if mant[31]=1, go to ROUND. Otherwise mant<<=1, exp-=1, stay in NORM. At most 31 shifts.
- ROUND:
  - m24=mant[31:8], guard=mant[7], sticky=|mant[6:0].
  - Round up iff guard & (sticky | m24[0]).
  - On carry out of m24: mantissa becomes 0x800000 and exp+=1.
  - result={sgn, exp[7:0], m24[22:0]}; go to OUT.
- OUT: out_valid=1; result is held stable while out_ready=0. When out_valid&out_ready, out_valid goes 0 on that edge and the state returns to IDLE. This costs one bubble cycle; there is no same-cycle re-accept.
- Latency: for a nonzero input with n leading zeros, out_valid rises n+2 edges after the accepting edge. For a zero input, out_valid rises 1 edge after the accepting edge.
- Exponent arithmetic uses a 9-bit internal register. The exponent range is 96..159, so there are no subnormal, infinity or NaN outputs for any legal FRAC_BITS. No saturation logic is required.
- out_valid and result are registered outputs with no combinational path from inputs.

Test Plan:
- Reset, then data_in=0x80000000, sign_in=0, out_ready=1 -> result=0x3F800000 (1.0); out_valid 2 edges after accept; in_ready high again the following cycle.
- data_in=0x4DBA7700 (CORDIC gain 0.60725), sign_in=0 -> one shift, result=0x3F1B74EE, latency 3 edges. The same input with sign_in=1 gives 0xBF1B74EE.
- Rounding:
  - 0x80000080 -> 0x3F800000 (tie, even, no round-up).
  - 0x80000180 -> 0x3F800002 (tie, odd, rounds up).
  - 0xFFFFFFFF -> 0x40000000 (mantissa carry, exponent increments).
- Extremes:
  - data_in=0x00000001 -> 31 shifts, result=0x30000000, out_valid at 33 edges.
  - data_in=0, sign_in=1 -> 0x00000000 after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> result and out_valid stable and in_ready=0 throughout. Assert in_valid with new data during this time -> the new data is ignored. out_ready=1 -> transfer completes, then return to IDLE.
- Async reset mid-NORM (input 0x00000001, reset_n pulsed low at shift 10, not aligned to clk) -> out_valid=0 and result=0 immediately. After release, a fresh 0x80000000 conversion gives 0x3F800000.

Source files
------------

// File: rtl/cordic_packer.sv
// Packs the unsigned fixed-point CORDIC X result plus a sign into IEEE-754 single.
// Normalises one bit per cycle, then rounds to nearest-even.
module cordic_packer #(
  parameter int FRAC_BITS = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic        sign_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    OUT
  } state_t;

  localparam logic [8:0] EXP0 = 9'(158 - FRAC_BITS);

  state_t      state, state_n;
  logic [31:0] mant, mant_n;
  logic [8:0]  expo, expo_n;
  logic        sgn, sgn_n;
  logic [31:0] res, res_n;
  logic        ov, ov_n;

  logic [23:0] m24;
  logic        guard;
  logic        sticky;
  logic        up;
  logic [24:0] sum;
  logic [23:0] m_rnd;
  logic [8:0]  exp_rnd;

  assign m24     = mant[31:8];
  assign guard   = mant[7];
  assign sticky  = |mant[6:0];
  assign up      = guard & (sticky | m24[0]);
  assign sum     = {1'b0, m24} + 25'(up);
  assign m_rnd   = sum[24] ? 24'h800000 : sum[23:0];
  assign exp_rnd = expo + 9'(sum[24]);

  assign in_ready  = (state == IDLE);
  assign out_valid = ov;
  assign result    = res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mant  <= '0;
      expo  <= '0;
      sgn   <= 1'b0;
      res   <= '0;
      ov    <= 1'b0;
    end else begin
      state <= state_n;
      mant  <= mant_n;
      expo  <= expo_n;
      sgn   <= sgn_n;
      res   <= res_n;
      ov    <= ov_n;
    end
  end

  always_comb begin
    state_n = state;
    mant_n  = mant;
    expo_n  = expo;
    sgn_n   = sgn;
    res_n   = res;
    ov_n    = ov;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          mant_n = data_in;
          expo_n = EXP0;
          sgn_n  = sign_in;
          res_n  = '0;
          // zero skips NORM but still spends one cycle in ROUND
          state_n = (data_in == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (mant[31]) begin
          state_n = ROUND;
        end else begin
          mant_n = mant << 1;
          expo_n = expo - 9'd1;
        end
      end
      ROUND: begin
        if (mant[31]) begin
          mant_n = {m_rnd, 8'h00};
          expo_n = exp_rnd;
          res_n  = {sgn, exp_rnd[7:0], m_rnd[22:0]};
        end else begin
          res_n = '0;
        end
        ov_n    = 1'b1;
        state_n = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_packer.sv
// Directed bench for cordic_packer: values, latency, rounding,
// backpressure and asynchronous reset.
module tb_cordic_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  cordic_packer #(.FRAC_BITS(31)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .sign_in(sign_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic convert(input logic [31:0] d, input logic s,
                         output int lat, output logic [31:0] r);
    @(negedge clk);
    data_in   = d;
    sign_in   = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    sign_in   = 1'b0;
    out_ready = 1'b0;
    #17;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    tests++;
    if (result !== 32'h0) begin
      fails++;
      $display("FAIL reset_result got=%h want=00000000", result);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_one();
    int lat;
    logic [31:0] r;
    convert(32'h80000000, 1'b0, lat, r);
    tests++;
    if (lat != 2) begin
      fails++;
      $display("FAIL one_latency got=%0d want=2", lat);
    end
    tests++;
    if (r !== 32'h3F800000) begin
      fails++;
      $display("FAIL one_result got=%h want=3F800000", r);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL one_in_ready_busy got=%b want=0", in_ready);
    end
    drain();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL one_after_xfer got=ov%b/ir%b want=ov0/ir1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_gain();
    int lat;
    logic [31:0] r;
    convert(32'h4DBA7700, 1'b0, lat, r);
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL gain_latency got=%0d want=3", lat);
    end
    tests++;
    if (r !== 32'h3F1B74EE) begin
      fails++;
      $display("FAIL gain_pos got=%h want=3F1B74EE", r);
    end
    drain();
    convert(32'h4DBA7700, 1'b1, lat, r);
    tests++;
    if (r !== 32'hBF1B74EE) begin
      fails++;
      $display("FAIL gain_neg got=%h want=BF1B74EE", r);
    end
    drain();
  endtask

  task automatic test_rounding();
    logic [31:0] din [3];
    logic [31:0] exp [3];
    int lat;
    logic [31:0] r;
    din[0] = 32'h80000080; exp[0] = 32'h3F800000;
    din[1] = 32'h80000180; exp[1] = 32'h3F800002;
    din[2] = 32'hFFFFFFFF; exp[2] = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      convert(din[i], 1'b0, lat, r);
      tests++;
      if (r !== exp[i]) begin
        fails++;
        $display("FAIL round_%0d in=%h got=%h want=%h", i, din[i], r, exp[i]);
      end
      drain();
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic [31:0] r;
    convert(32'h00000001, 1'b0, lat, r);
    tests++;
    if (lat != 33) begin
      fails++;
      $display("FAIL min_latency got=%0d want=33", lat);
    end
    tests++;
    if (r !== 32'h30000000) begin
      fails++;
      $display("FAIL min_result got=%h want=30000000", r);
    end
    drain();
    convert(32'h00000000, 1'b1, lat, r);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL zero_latency got=%0d want=1", lat);
    end
    tests++;
    if (r !== 32'h00000000) begin
      fails++;
      $display("FAIL zero_result got=%h want=00000000", r);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] r;
    convert(32'h80000180, 1'b1, lat, r);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_in  = 32'hFFFFFFFF;
      sign_in  = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result !== 32'hBF800002) begin
        fails++;
        $display("FAIL bp_hold_%0d got=ov%b/ir%b/%h want=ov1/ir0/BF800002",
                 i, out_valid, in_ready, result);
      end
    end
    in_valid = 1'b0;
    drain();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got=ov%b/ir%b want=ov0/ir1",
               out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ignored got=ov%b/ir%b want=ov0/ir1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [31:0] r;
    @(negedge clk);
    data_in   = 32'h00000001;
    sign_in   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL areset_clear got=ov%b/%h want=ov0/00000000",
               out_valid, result);
    end
    #7;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL areset_no_partial got=ov%b/ir%b want=ov0/ir1",
               out_valid, in_ready);
    end
    convert(32'h80000000, 1'b0, lat, r);
    tests++;
    if (r !== 32'h3F800000 || lat != 2) begin
      fails++;
      $display("FAIL areset_fresh got=%h/lat%0d want=3F800000/lat2", r, lat);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_one();
    test_gain();
    test_rounding();
    test_extremes();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
